// File: rtl/fpu_result_demux_4ch.sv
// Purpose: steers one FP32 result stream to one of four consumers, each behind a
//          one-entry output register; optional per-channel drain counters (FPU_DEMUX_STATS_EN).
// Latency: 1 cycle from accept to out_valid. Backpressure: a stalled channel only blocks inputs addressed to it.
module fpu_result_demux_4ch #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 busy,
    output logic [4*CNT_W-1:0]   xfer_cnt
);

    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic             acc;
    logic [3:0]       drain;
    logic [3:0]       load;

    // A full channel can still accept when its consumer drains in the same cycle.
    always_comb begin
        in_ready = ~valid_q[in_sel] | out_ready[in_sel];
        acc      = in_valid & in_ready;
        drain    = valid_q & out_ready;
        for (int k = 0; k < 4; k++) begin
            load[k]    = acc && (in_sel == 2'(k));
            valid_d[k] = load[k] | (valid_q[k] & ~drain[k]);
            data_d[k]  = load[k] ? in_data : data_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    always_comb begin
        out_valid = valid_q;
        busy      = |valid_q;
        out_data  = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

`ifdef FPU_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        xfer_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = (drain[k] && (cnt_q[k] != {CNT_W{1'b1}})) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
            xfer_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
`else
    assign xfer_cnt = '0;
`endif

endmodule
